// File: rtl/multi_channel_stream_cipher.sv
// rtl/multi_channel_stream_cipher.sv - per-channel LFSR XOR stream cipher for pixel streams
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   seed_load, seed          one-cycle pulse loading a new 32-bit key seed
//   mode                     0 = bypass, 1 = XOR with keystream (sampled per accepted pixel)
//   in_valid/in_ready/in_data            pixel input, channel c at [c*W +: W]
//   out_valid/out_ready/out_data/out_last registered result stream, last on final frame pixel
//   key_ready                keystream is live (RUN)
//   done                     frame finished, waiting for the next seed_load
module multi_channel_stream_cipher #(
  parameter int CH        = 3,
  parameter int W         = 8,
  parameter int FRAME_PIX = 65536,
  parameter int WARMUP    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            seed_load,
  input  logic [31:0]     seed,
  input  logic            mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH*W-1:0] out_data,
  output logic            out_last,
  output logic            key_ready,
  output logic            done
);

  localparam int CW    = $clog2(FRAME_PIX + 1);
  localparam int WW    = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int WLAST = (WARMUP > 0) ? WARMUP - 1 : 0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WARMUP = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  // With no warm-up the seed goes straight to live keystream.
  localparam logic [1:0] S_START  = (WARMUP > 0) ? S_WARMUP : S_RUN;

  logic [1:0]          state;
  logic [WW-1:0]       warm_cnt;
  logic [CW-1:0]       pix_cnt;
  logic [CH-1:0][31:0] lfsr;
  logic [CH-1:0][31:0] lfsr_next;
  logic [CH-1:0][31:0] lfsr_seed;
  logic [CH*W-1:0]     pix_next;
  logic                accept;
  logic                drain;

  // Galois right-shift step with feedback taps 0x80200003.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  always_comb begin
    lfsr_next = '0;
    lfsr_seed = '0;
    pix_next  = '0;
    for (int c = 0; c < CH; c++) begin
      lfsr_next[c] = lfsr_step(lfsr[c]);
      // Golden-ratio multiples decorrelate the channels; an all-zero state would lock up.
      lfsr_seed[c] = seed ^ (32'(c + 1) * 32'h9E3779B9);
      if (lfsr_seed[c] == 32'h0) begin
        lfsr_seed[c] = 32'h1;
      end
      pix_next[c*W +: W] = in_data[c*W +: W] ^ ({W{mode}} & lfsr[c][W-1:0]);
    end
  end

  // seed_load gates in_ready so a pixel is never keyed from a state about to be replaced.
  assign in_ready  = (state == S_RUN) && (pix_cnt < CW'(FRAME_PIX)) &&
                     (!out_valid || out_ready) && !seed_load;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign key_ready = (state == S_RUN);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      warm_cnt  <= '0;
      pix_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        lfsr[c] <= 32'h1;
      end
    end else if (seed_load) begin
      // Reload from any state; a pending output beat belongs to the old key and is dropped.
      state     <= S_START;
      warm_cnt  <= '0;
      pix_cnt   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      lfsr      <= lfsr_seed;
    end else begin
      if (state == S_WARMUP) begin
        lfsr     <= lfsr_next;
        warm_cnt <= warm_cnt + 1'b1;
        if (warm_cnt == WW'(WLAST)) begin
          state <= S_RUN;
        end
      end
      // Accept takes priority over drain so a simultaneous drain+accept refills with no bubble.
      if (accept) begin
        lfsr      <= lfsr_next;
        out_data  <= pix_next;
        out_last  <= (pix_cnt == CW'(FRAME_PIX - 1));
        out_valid <= 1'b1;
        pix_cnt   <= pix_cnt + 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (drain && out_last) begin
        state <= S_DONE;
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_stream_cipher.sv
// tb/tb_multi_channel_stream_cipher.sv - self-checking bench for multi_channel_stream_cipher
module tb_multi_channel_stream_cipher;

  localparam int CH      = 3;
  localparam int W       = 8;
  localparam int DW      = CH * W;
  localparam int FRAME   = 4;
  localparam int WARM    = 3;
  localparam int Z_FRAME = 6;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          seed_load = 1'b0;
  logic [31:0]   seed      = 32'h0;
  logic          mode      = 1'b0;
  logic          in_valid  = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic          out_ready = 1'b0;

  logic          in_ready, out_valid, out_last, key_ready, done;
  logic [DW-1:0] out_data;
  logic          z_in_ready, z_out_valid, z_out_last, z_key_ready, z_done;
  logic [DW-1:0] z_out_data;

  multi_channel_stream_cipher #(.CH(CH), .W(W), .FRAME_PIX(FRAME), .WARMUP(WARM)) u_dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .key_ready(key_ready), .done(done)
  );

  multi_channel_stream_cipher #(.CH(CH), .W(W), .FRAME_PIX(Z_FRAME), .WARMUP(0)) u_zero (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .mode(mode),
    .in_valid(in_valid), .in_ready(z_in_ready), .in_data(in_data),
    .out_valid(z_out_valid), .out_ready(out_ready), .out_data(z_out_data), .out_last(z_out_last),
    .key_ready(z_key_ready), .done(z_done)
  );

  always #5 clk = ~clk;

  int            n_pass  = 0;
  int            n_total = 0;
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] acc_in[$];
  logic [DW-1:0] got_out[$];
  bit            acc_mode[$];
  bit            got_last[$];
  int            acc_cyc[$];
  int            last_drain_cyc;
  int            done_cyc;

  // Reference: LFSR state of channel c after n advances from seed load, in plain arithmetic.
  function automatic logic [31:0] m_state(input logic [31:0] sd, input int c, input int n);
    logic [31:0] s;
    s = sd ^ (32'(c + 1) * 32'h9E3779B9);
    if (s == 32'd0) s = 32'd1;
    for (int i = 0; i < n; i++) begin
      if (s % 2 == 1) s = (s / 2) ^ 32'h80200003;
      else            s = s / 2;
    end
    return s;
  endfunction

  // Expected output for the idx-th accepted pixel of a frame.
  function automatic logic [DW-1:0] exp_pix(input logic [31:0] sd, input int warm, input int idx,
                                            input bit md, input logic [DW-1:0] din);
    logic [DW-1:0] r;
    logic [31:0]   st;
    for (int c = 0; c < CH; c++) begin
      st = m_state(sd, c, warm + idx);
      r[c*W +: W] = din[c*W +: W] ^ (md ? st[W-1:0] : {W{1'b0}});
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_pix();
    return DW'($urandom);
  endfunction

  task automatic do_reset();
    rst = 1'b1; seed_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_seed(input logic [31:0] s);
    seed_load = 1'b1;
    seed = s;
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  task automatic wait_key(output int cyc);
    cyc = 0;
    while (!key_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Streams src_q into the main DUT, recording accepted inputs and drained outputs.
  task automatic run_stream(input int budget, input bit rand_ready, input bit rand_mode,
                            input bit fix_mode, output bit timed_out);
    int k, cyc;
    bit acc_now, fin;
    k = 0; cyc = 0; fin = 0; timed_out = 1;
    acc_in.delete(); acc_mode.delete(); acc_cyc.delete(); got_out.delete(); got_last.delete();
    last_drain_cyc = -1; done_cyc = -1;
    while (!fin && cyc < budget) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k < src_q.size()) begin
        in_valid = 1'b1; in_data = src_q[k];
      end else begin
        in_valid = 1'b0; in_data = rnd_pix();
      end
      mode = rand_mode ? 1'($urandom_range(0, 1)) : fix_mode;
      #1;
      acc_now = in_valid && in_ready;
      if (out_valid && out_ready) begin
        got_out.push_back(out_data);
        got_last.push_back(out_last);
        if (out_last) last_drain_cyc = cyc;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (acc_now) begin
        acc_in.push_back(in_data); acc_mode.push_back(mode); acc_cyc.push_back(cyc); k++;
      end
      if (k >= src_q.size() && !acc_now && !out_valid) begin
        fin = 1; timed_out = 0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    int cyc;
    rst = 1'b1; in_valid = 1'b1; in_data = rnd_pix(); out_ready = 1'b1; mode = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({in_ready, out_valid, out_last, key_ready, done, out_data} !== '0)
      $display("FAIL reset_hold: got %b/%b/%b/%b/%b data %h, expected all zero",
               in_ready, out_valid, out_last, key_ready, done, out_data);
    else n_pass++;
    n_total++;
    if ({z_in_ready, z_out_valid, z_out_last, z_key_ready, z_done, z_out_data} !== '0)
      $display("FAIL reset_hold_zero_warmup: got %b/%b/%b/%b/%b data %h, expected all zero",
               z_in_ready, z_out_valid, z_out_last, z_key_ready, z_done, z_out_data);
    else n_pass++;

    do_reset();
    load_seed(32'h1234_5678);
    wait_key(cyc);
    in_valid = 1'b1; out_ready = 1'b0; mode = 1'b1; in_data = rnd_pix();
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL reset_prestate: out_valid %b expected 1", out_valid);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({in_ready, out_valid, out_last, key_ready, done, out_data} !== '0)
      $display("FAIL reset_midstream: got %b/%b/%b/%b/%b data %h, expected all zero",
               in_ready, out_valid, out_last, key_ready, done, out_data);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    bad = 0;
    repeat (6) begin
      #1;
      if (in_ready !== 1'b0 || key_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    n_total++;
    if (bad != 0) $display("FAIL reset_needs_seed: %0d active cycles, expected 0", bad);
    else n_pass++;
    in_valid = 1'b0;
  endtask

  task automatic test_keystream();
    logic [DW-1:0] d0, d1;
    logic [7:0]    ch0;
    do_reset();
    load_seed(32'h9E3779B9);
    mode = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    d0 = rnd_pix(); d0[7:0] = 8'h55; in_data = d0;
    #1;
    n_total++;
    if ({z_key_ready, z_in_ready} !== 2'b11)
      $display("FAIL keystream_run: key_ready/in_ready %b expected 11", {z_key_ready, z_in_ready});
    else n_pass++;
    @(negedge clk);
    d1 = rnd_pix(); d1[7:0] = 8'h55; in_data = d1;
    ch0 = z_out_data[7:0];
    n_total++;
    if (z_out_valid !== 1'b1 || ch0 !== 8'h54)
      $display("FAIL keystream_pix0: valid %b ch0 %h expected 1 54", z_out_valid, ch0);
    else n_pass++;
    n_total++;
    if (z_out_data !== exp_pix(32'h9E3779B9, 0, 0, 1'b1, d0))
      $display("FAIL keystream_pix0_all: got %h expected %h", z_out_data, exp_pix(32'h9E3779B9, 0, 0, 1'b1, d0));
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    ch0 = z_out_data[7:0];
    n_total++;
    if (z_out_valid !== 1'b1 || ch0 !== 8'h56)
      $display("FAIL keystream_pix1: valid %b ch0 %h expected 1 56", z_out_valid, ch0);
    else n_pass++;
    n_total++;
    if (z_out_data !== exp_pix(32'h9E3779B9, 0, 1, 1'b1, d1))
      $display("FAIL keystream_pix1_all: got %h expected %h", z_out_data, exp_pix(32'h9E3779B9, 0, 1, 1'b1, d1));
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d0, d1, e0, e1;
    logic [31:0]   s;
    int            cyc;
    s = $urandom;
    do_reset();
    load_seed(s);
    wait_key(cyc);
    d0 = rnd_pix(); d1 = rnd_pix();
    e0 = exp_pix(s, WARM, 0, 1'b1, d0);
    e1 = exp_pix(s, WARM, 1, 1'b1, d1);
    mode = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_data = d0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL bp_first_ready: in_ready %b expected 1", in_ready);
    else n_pass++;
    @(negedge clk);
    in_data = d1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if (out_valid !== 1'b1 || out_data !== e0 || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d: valid %b data %h in_ready %b expected 1 %h 0",
                 i, out_valid, out_data, in_ready, e0);
      else n_pass++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready: in_ready %b expected 1", in_ready);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b1 || out_data !== e1)
      $display("FAIL bp_second_pixel: valid %b data %h expected 1 %h", out_valid, out_data, e1);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL bp_drained: out_valid %b expected 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_frame_end();
    logic [31:0] s;
    int          cyc, bad;
    bit          to;
    s = $urandom;
    do_reset();
    load_seed(s);
    wait_key(cyc);
    src_q.delete();
    for (int i = 0; i < FRAME; i++) src_q.push_back(rnd_pix());
    run_stream(60, 1'b0, 1'b0, 1'b1, to);
    n_total++;
    if (to !== 1'b0 || got_out.size() != FRAME)
      $display("FAIL frame_count: timeout %b beats %0d expected 0 %0d", to, got_out.size(), FRAME);
    else n_pass++;
    for (int i = 0; i < got_out.size() && i < FRAME; i++) begin
      n_total++;
      if (got_out[i] !== exp_pix(s, WARM, i, 1'b1, src_q[i]) || got_last[i] !== (i == FRAME - 1))
        $display("FAIL frame_beat%0d: data %h last %b expected %h %b", i, got_out[i], got_last[i],
                 exp_pix(s, WARM, i, 1'b1, src_q[i]), (i == FRAME - 1));
      else n_pass++;
    end
    n_total++;
    if (acc_cyc.size() != FRAME || acc_cyc[FRAME-1] - acc_cyc[0] != FRAME - 1)
      $display("FAIL frame_full_rate: %0d accepts, span %0d expected %0d", acc_cyc.size(),
               (acc_cyc.size() == FRAME) ? acc_cyc[FRAME-1] - acc_cyc[0] : -1, FRAME - 1);
    else n_pass++;
    n_total++;
    if (last_drain_cyc < 0 || done_cyc != last_drain_cyc + 1)
      $display("FAIL frame_done_timing: done at %0d, last drained at %0d", done_cyc, last_drain_cyc);
    else n_pass++;
    in_valid = 1'b1; in_data = rnd_pix(); out_ready = 1'b1; mode = 1'b1;
    bad = 0;
    repeat (4) begin
      #1;
      if (in_ready !== 1'b0 || done !== 1'b1 || out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_total++;
    if (bad != 0) $display("FAIL frame_closed: %0d bad cycles expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_mode_roundtrip();
    logic [31:0]   s;
    logic [DW-1:0] orig[$];
    logic [DW-1:0] cipher[$];
    int            cyc, bad;
    bit            to;

    s = $urandom;
    load_seed(s);
    wait_key(cyc);
    src_q.delete();
    for (int i = 0; i < FRAME; i++) src_q.push_back(rnd_pix());
    run_stream(60, 1'b0, 1'b0, 1'b0, to);
    bad = 0;
    for (int i = 0; i < got_out.size(); i++) if (got_out[i] !== src_q[i]) bad++;
    n_total++;
    if (to !== 1'b0 || got_out.size() != FRAME || bad != 0)
      $display("FAIL bypass: timeout %b beats %0d mismatched %0d expected 0 %0d 0", to, got_out.size(), bad, FRAME);
    else n_pass++;

    s = $urandom;
    load_seed(s);
    wait_key(cyc);
    src_q.delete();
    for (int i = 0; i < FRAME; i++) src_q.push_back(rnd_pix());
    run_stream(200, 1'b1, 1'b1, 1'b0, to);
    bad = 0;
    for (int i = 0; i < got_out.size(); i++)
      if (got_out[i] !== exp_pix(s, WARM, i, acc_mode[i], acc_in[i])) bad++;
    n_total++;
    if (to !== 1'b0 || got_out.size() != FRAME || bad != 0)
      $display("FAIL mixed_mode: timeout %b beats %0d mismatched %0d expected 0 %0d 0", to, got_out.size(), bad, FRAME);
    else n_pass++;

    s = $urandom;
    load_seed(s);
    wait_key(cyc);
    src_q.delete();
    for (int i = 0; i < FRAME; i++) src_q.push_back(rnd_pix());
    orig = src_q;
    run_stream(200, 1'b1, 1'b0, 1'b1, to);
    cipher = got_out;
    n_total++;
    if (to !== 1'b0 || cipher.size() != FRAME)
      $display("FAIL encrypt_pass: timeout %b beats %0d expected 0 %0d", to, cipher.size(), FRAME);
    else n_pass++;
    load_seed(s);
    wait_key(cyc);
    src_q = cipher;
    run_stream(200, 1'b1, 1'b0, 1'b1, to);
    bad = 0;
    for (int i = 0; i < got_out.size() && i < orig.size(); i++) if (got_out[i] !== orig[i]) bad++;
    n_total++;
    if (to !== 1'b0 || got_out.size() != FRAME || bad != 0)
      $display("FAIL roundtrip: timeout %b beats %0d mismatched %0d expected 0 %0d 0", to, got_out.size(), bad, FRAME);
    else n_pass++;
  endtask

  task automatic test_seed_reload();
    logic [31:0] s;
    int          cyc, bad;
    bit          to;
    s = $urandom;
    do_reset();
    load_seed(s);
    wait_key(cyc);
    n_total++;
    if (cyc != WARM) $display("FAIL warmup_length: %0d cycles expected %0d", cyc, WARM);
    else n_pass++;
    in_valid = 1'b1; out_ready = 1'b0; mode = 1'b1; in_data = rnd_pix();
    @(negedge clk);
    #1;
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL reload_pending: out_valid %b expected 1", out_valid);
    else n_pass++;
    seed_load = 1'b1; seed = s;
    #1;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL reload_gates_ready: in_ready %b expected 0", in_ready);
    else n_pass++;
    @(negedge clk);
    seed_load = 1'b0; in_valid = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || key_ready !== 1'b0)
      $display("FAIL reload_drop: out_valid %b key_ready %b expected 0 0", out_valid, key_ready);
    else n_pass++;
    wait_key(cyc);
    n_total++;
    if (cyc != WARM) $display("FAIL rewarmup_length: %0d cycles expected %0d", cyc, WARM);
    else n_pass++;
    src_q.delete();
    for (int i = 0; i < FRAME; i++) src_q.push_back(rnd_pix());
    run_stream(60, 1'b0, 1'b0, 1'b1, to);
    bad = 0;
    for (int i = 0; i < got_out.size() && i < FRAME; i++)
      if (got_out[i] !== exp_pix(s, WARM, i, 1'b1, src_q[i])) bad++;
    n_total++;
    if (to !== 1'b0 || got_out.size() != FRAME || bad != 0)
      $display("FAIL reload_keystream: timeout %b beats %0d mismatched %0d expected 0 %0d 0", to, got_out.size(), bad, FRAME);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, %0d/%0d checks passed so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_keystream();
    test_backpressure();
    test_frame_end();
    test_mode_roundtrip();
    test_seed_reload();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
